// File: rtl/ws2812_rx_pkg.sv
// ws_pkg
// Shared definitions for the WS2812 strip receive path: the receiver state
// encoding, the word size of one pixel and the default timing constants that
// the strip driver also uses (all cycle counts at a 48 MHz clock).
package ws_pkg;

   typedef enum logic [1:0] {
      SYNC,
      LOW,
      HIGH
   } rx_state_t;

   localparam int BITS_PER_LED = 24;

   localparam int DEF_THRESH_CYCLES = 29;
   localparam int DEF_MIN_HIGH      = 8;
   localparam int DEF_MAX_HIGH      = 60;
   localparam int DEF_RESET_CYCLES  = 2400;
   localparam int DEF_N_LEDS        = 6;

endpackage

// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if
// Bundles the serial strip line and the decoded pixel/frame outputs of the
// receiver.
//   din         : serial strip data (asynchronous to clk)
//   pixel       : last decoded pixel, first wire bit in bit 23
//   pixel_valid : one-cycle pulse per decoded pixel
//   frame       : last completed frame, first pixel at the MSB end
//   frame_valid : one-cycle pulse when frame updates
//   led_count   : pixels in the last completed frame (saturating)
//   err         : one-cycle pulse on a protocol error
// modport master: the side that drives din and consumes the results.
// modport slave : the receiver itself.
interface ws2812_rx_if #(
   parameter int N_LEDS = 6
);
   import ws_pkg::*;

   logic                           din;
   logic [BITS_PER_LED-1:0]        pixel;
   logic                           pixel_valid;
   logic [BITS_PER_LED*N_LEDS-1:0] frame;
   logic                           frame_valid;
   logic [9:0]                     led_count;
   logic                           err;

   modport master (
      output din,
      input  pixel, pixel_valid, frame, frame_valid, led_count, err
   );

   modport slave (
      input  din,
      output pixel, pixel_valid, frame, frame_valid, led_count, err
   );

endinterface

// File: rtl/ws2812_rx_din_sync.sv
// din_sync
// Brings the asynchronous strip line into the clk domain through two flops
// and keeps one extra delayed copy so edges can be detected.
//   clk, rst : clock and synchronous active-high reset
//   din      : raw strip line
//   din_s    : synchronized level
//   rise     : din_s is high this cycle and was low the cycle before
//   fall     : din_s is low this cycle and was high the cycle before
module din_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic din_s,
   output logic rise,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = din;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign din_s = sync_q;
   assign rise  = sync_q & ~prev_q;
   assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx
// WS2812 NRZ receiver. Measures the width of each high pulse on the strip line
// to recover bits, assembles 24-bit pixels, and on a long low (latch) gap
// publishes the pixels collected since the previous gap as a frame.
//   clk, rst : clock and synchronous active-high reset
//   bus      : ws2812_rx_if slave modport (din in; pixel/frame results out)
// After reset or any protocol error the receiver waits for a full latch gap
// before decoding again, so a frame joined part-way through is ignored.
module ws2812_rx
   import ws_pkg::*;
#(
   parameter int THRESH_CYCLES = DEF_THRESH_CYCLES,
   parameter int MIN_HIGH      = DEF_MIN_HIGH,
   parameter int MAX_HIGH      = DEF_MAX_HIGH,
   parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
   parameter int N_LEDS        = DEF_N_LEDS
) (
   input logic        clk,
   input logic        rst,
   ws2812_rx_if.slave bus
);

   localparam int LW = $clog2(RESET_CYCLES + 1);
   localparam logic [LW-1:0] LOW_SAT  = LW'(RESET_CYCLES);
   localparam logic [LW-1:0] LOW_PRE  = LW'(RESET_CYCLES - 1);
   localparam logic [6:0]    HIGH_SAT = 7'(MAX_HIGH + 1);
   localparam logic [6:0]    MIN_H    = 7'(MIN_HIGH);
   localparam logic [6:0]    MAX_H    = 7'(MAX_HIGH);
   localparam logic [6:0]    THR      = 7'(THRESH_CYCLES);

   logic din_s, rise, fall;

   din_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (bus.din),
      .din_s (din_s),
      .rise  (rise),
      .fall  (fall)
   );

   rx_state_t                           state_q, state_d;
   logic [LW-1:0]                       low_cnt_q, low_cnt_d;
   logic [6:0]                          high_cnt_q, high_cnt_d;
   logic                                gap_q, gap_d;
   logic [BITS_PER_LED-1:0]             shreg_q, shreg_d;
   logic [4:0]                          bit_cnt_q, bit_cnt_d;
   logic [9:0]                          pix_cnt_q, pix_cnt_d;
   logic [N_LEDS-1:0][BITS_PER_LED-1:0] shadow_q, shadow_d;
   logic [BITS_PER_LED-1:0]             pixel_q, pixel_d;
   logic                                pixel_valid_q, pixel_valid_d;
   logic [N_LEDS-1:0][BITS_PER_LED-1:0] frame_q, frame_d;
   logic                                frame_valid_q, frame_valid_d;
   logic [9:0]                          led_count_q, led_count_d;
   logic                                err_q, err_d;
   logic [BITS_PER_LED-1:0]             new_word;
   logic                                rx_error;

   // Next-state logic. gap_q marks the single cycle in which low_cnt has just
   // reached RESET_CYCLES; latch handling happens there, which puts the
   // frame_valid pulse RESET_CYCLES+1 cycles after the last falling edge.
   // Latch handling and the state machine never touch the same registers in
   // the same cycle because gap_q is only ever set while the machine is LOW.
   always_comb begin
      state_d       = state_q;
      low_cnt_d     = low_cnt_q;
      high_cnt_d    = high_cnt_q;
      gap_d         = 1'b0;
      shreg_d       = shreg_q;
      bit_cnt_d     = bit_cnt_q;
      pix_cnt_d     = pix_cnt_q;
      shadow_d      = shadow_q;
      pixel_d       = pixel_q;
      pixel_valid_d = 1'b0;
      frame_d       = frame_q;
      frame_valid_d = 1'b0;
      led_count_d   = led_count_q;
      err_d         = 1'b0;
      rx_error      = 1'b0;
      new_word      = {shreg_q[BITS_PER_LED-2:0], (high_cnt_q >= THR)};

      if (gap_q) begin
         if (pix_cnt_q != 10'd0) begin
            frame_d       = shadow_q;
            led_count_d   = pix_cnt_q;
            frame_valid_d = 1'b1;
            shadow_d      = '0;
            pix_cnt_d     = 10'd0;
         end
         if (bit_cnt_q != 5'd0) begin
            err_d     = 1'b1;
            bit_cnt_d = 5'd0;
            shreg_d   = '0;
         end
      end

      case (state_q)
         SYNC: begin
            if (din_s) begin
               low_cnt_d = '0;
            end else begin
               if (low_cnt_q != LOW_SAT) low_cnt_d = low_cnt_q + LW'(1);
               if (low_cnt_q >= LOW_PRE) state_d = LOW;
            end
         end
         LOW: begin
            if (rise) begin
               state_d    = HIGH;
               high_cnt_d = 7'd1;
            end else begin
               if (low_cnt_q != LOW_SAT) low_cnt_d = low_cnt_q + LW'(1);
               if (low_cnt_q == LOW_PRE) gap_d = 1'b1;
            end
         end
         HIGH: begin
            if (high_cnt_q != HIGH_SAT) high_cnt_d = high_cnt_q + 7'd1;
            if (fall) begin
               low_cnt_d = LW'(1);
               if (high_cnt_q >= MIN_H && high_cnt_q <= MAX_H) begin
                  state_d = LOW;
                  shreg_d = new_word;
                  if (bit_cnt_q == 5'(BITS_PER_LED - 1)) begin
                     pixel_d       = new_word;
                     pixel_valid_d = 1'b1;
                     bit_cnt_d     = 5'd0;
                     // Slot 0 sits at the MSB end; pixels past N_LEDS match no slot.
                     for (int i = 0; i < N_LEDS; i++) begin
                        if (pix_cnt_q == 10'(i)) shadow_d[N_LEDS-1-i] = new_word;
                     end
                     if (pix_cnt_q != 10'h3FF) pix_cnt_d = pix_cnt_q + 10'd1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end else begin
                  rx_error = 1'b1;
               end
            end else if (high_cnt_q > MAX_H) begin
               low_cnt_d = '0;
               rx_error  = 1'b1;
            end
         end
         default: state_d = SYNC;
      endcase

      // Any malformed pulse throws away everything collected since the last gap.
      if (rx_error) begin
         err_d     = 1'b1;
         shreg_d   = '0;
         bit_cnt_d = 5'd0;
         shadow_d  = '0;
         pix_cnt_d = 10'd0;
         state_d   = SYNC;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= SYNC;
         low_cnt_q     <= '0;
         high_cnt_q    <= 7'd0;
         gap_q         <= 1'b0;
         shreg_q       <= '0;
         bit_cnt_q     <= 5'd0;
         pix_cnt_q     <= 10'd0;
         shadow_q      <= '0;
         pixel_q       <= '0;
         pixel_valid_q <= 1'b0;
         frame_q       <= '0;
         frame_valid_q <= 1'b0;
         led_count_q   <= 10'd0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         low_cnt_q     <= low_cnt_d;
         high_cnt_q    <= high_cnt_d;
         gap_q         <= gap_d;
         shreg_q       <= shreg_d;
         bit_cnt_q     <= bit_cnt_d;
         pix_cnt_q     <= pix_cnt_d;
         shadow_q      <= shadow_d;
         pixel_q       <= pixel_d;
         pixel_valid_q <= pixel_valid_d;
         frame_q       <= frame_d;
         frame_valid_q <= frame_valid_d;
         led_count_q   <= led_count_d;
         err_q         <= err_d;
      end
   end

   assign bus.pixel       = pixel_q;
   assign bus.pixel_valid = pixel_valid_q;
   assign bus.frame       = frame_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.led_count   = led_count_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx
// Drives WS2812 waveforms into ws2812_rx and compares every pixel, frame and
// error pulse against a pulse-level model of the protocol: each high pulse is
// classified by width, pixels are gathered in arrays, and each latch gap turns
// the gathered pixels into an expected frame.
module tb_ws2812_rx;
   import ws_pkg::*;

   localparam int N      = 6;
   localparam int THRESH = 29;
   localparam int MINH   = 8;
   localparam int MAXH   = 60;
   localparam int RC     = 2400;
   localparam int GAP    = 2500;
   localparam int FW     = 24 * N;

   localparam int EV_PIXEL = 0;
   localparam int EV_FRAME = 1;
   localparam int EV_ERR   = 2;

   typedef struct {
      int            kind;
      logic [FW-1:0] data;
      int            cnt;
      int            cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ws2812_rx_if #(.N_LEDS(N)) bus ();

   ws2812_rx #(
      .THRESH_CYCLES (THRESH),
      .MIN_HIGH      (MINH),
      .MAX_HIGH      (MAXH),
      .RESET_CYCLES  (RC),
      .N_LEDS        (N)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   ev_t expQ[$];
   ev_t gotQ[$];
   int  cycCnt      = 0;
   int  errors      = 0;
   int  checks      = 0;
   int  lastFallCyc = 0;

   bit          modelSynced;
   int          modelBits;
   int          modelPix;
   logic [23:0] modelShreg;
   logic [23:0] modelShadow [N];

   // Free-running cycle count so pulse timing can be compared against the
   // cycle in which the bench changed din.
   always @(posedge clk) cycCnt <= cycCnt + 1;

   // Collects DUT pulses on the falling edge, away from the sampling edge.
   always @(negedge clk) begin
      ev_t e;
      e.cnt = 0;
      e.cyc = cycCnt;
      if (bus.pixel_valid) begin
         e.kind = EV_PIXEL; e.data = FW'(bus.pixel); e.cnt = 0;
         gotQ.push_back(e);
      end
      if (bus.frame_valid) begin
         e.kind = EV_FRAME; e.data = bus.frame; e.cnt = int'(bus.led_count);
         gotQ.push_back(e);
      end
      if (bus.err) begin
         e.kind = EV_ERR; e.data = '0; e.cnt = 0;
         gotQ.push_back(e);
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pushExp(input int kind, input logic [FW-1:0] data, input int cnt);
      ev_t e;
      e.kind = kind; e.data = data; e.cnt = cnt; e.cyc = 0;
      expQ.push_back(e);
   endtask

   task automatic modelReset();
      modelSynced = 1'b0;
      modelBits   = 0;
      modelPix    = 0;
      modelShreg  = '0;
      for (int i = 0; i < N; i++) modelShadow[i] = '0;
   endtask

   // One complete high pulse of width w as seen by the receiver.
   task automatic modelPulse(input int w);
      if (!modelSynced) return;
      if (w < MINH || w > MAXH) begin
         pushExp(EV_ERR, '0, 0);
         modelReset();
         return;
      end
      modelShreg = {modelShreg[22:0], (w >= THRESH) ? 1'b1 : 1'b0};
      modelBits++;
      if (modelBits == 24) begin
         pushExp(EV_PIXEL, FW'(modelShreg), 0);
         if (modelPix < N) modelShadow[modelPix] = modelShreg;
         if (modelPix < 1023) modelPix++;
         modelBits = 0;
      end
   endtask

   task automatic modelGap();
      logic [FW-1:0] f;
      if (!modelSynced) begin
         modelSynced = 1'b1;
         return;
      end
      if (modelPix > 0) begin
         f = '0;
         for (int i = 0; i < N; i++) if (i < modelPix) f[FW-1-24*i -: 24] = modelShadow[i];
         pushExp(EV_FRAME, f, modelPix);
         modelPix = 0;
         for (int i = 0; i < N; i++) modelShadow[i] = '0;
      end
      if (modelBits > 0) begin
         pushExp(EV_ERR, '0, 0);
         modelBits  = 0;
         modelShreg = '0;
      end
   endtask

   // Holds din at a level for a number of cycles; always returns 1 time unit
   // after a rising clock edge.
   task automatic applyStimulus(input logic level, input int cycles);
      bus.din = level;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic sendPulse(input int hi, input int lo);
      bus.din = 1'b1;
      repeat (hi) @(posedge clk);
      #1;
      lastFallCyc = cycCnt;
      modelPulse(hi);
      applyStimulus(1'b0, lo);
   endtask

   task automatic sendBit(input logic b);
      if (b) sendPulse(38, 22);
      else   sendPulse(19, 41);
   endtask

   task automatic sendPixel(input logic [23:0] v);
      for (int i = 23; i >= 0; i--) sendBit(v[i]);
   endtask

   task automatic sendRandBit(input logic b);
      int hi;
      hi = b ? int'($urandom_range(MAXH, THRESH)) : int'($urandom_range(THRESH - 1, MINH));
      sendPulse(hi, (MAXH + 2 - hi) + int'($urandom_range(8, 0)));
   endtask

   task automatic sendGap();
      applyStimulus(1'b0, GAP);
      modelGap();
   endtask

   task automatic checkEvents(input string name);
      int n;
      repeat (20) @(posedge clk);
      #1;
      checkOutput({name, "_event_count"}, FW'(gotQ.size()), FW'(expQ.size()));
      n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
      for (int i = 0; i < n; i++) begin
         checkOutput({name, "_kind"}, FW'(gotQ[i].kind), FW'(expQ[i].kind));
         checkOutput({name, "_data"}, gotQ[i].data, expQ[i].data);
         if (expQ[i].kind == EV_FRAME)
            checkOutput({name, "_led_count"}, FW'(gotQ[i].cnt), FW'(expQ[i].cnt));
      end
      gotQ.delete();
      expQ.delete();
   endtask

   task automatic doReset(input string name);
      rst     = 1'b1;
      bus.din = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput({name, "_pixel"},       FW'(bus.pixel),       '0);
      checkOutput({name, "_pixel_valid"}, FW'(bus.pixel_valid), '0);
      checkOutput({name, "_frame"},       bus.frame,            '0);
      checkOutput({name, "_frame_valid"}, FW'(bus.frame_valid), '0);
      checkOutput({name, "_led_count"},   FW'(bus.led_count),   '0);
      checkOutput({name, "_err"},         FW'(bus.err),         '0);
      rst = 1'b0;
      modelReset();
      gotQ.delete();
      expQ.delete();
   endtask

   initial begin
      int fallK;
      int npix;
      bus.din = 1'b0;
      modelReset();
      doReset("reset");
      sendGap();

      // Single pixel: frame holds it in slot 0, latency of pulses checked.
      sendPixel(24'hFF0000);
      fallK = lastFallCyc;
      sendGap();
      if (gotQ.size() == 2) begin
         checkOutput("s1_pixel_latency", FW'(gotQ[0].cyc), FW'(fallK + 3));
         checkOutput("s1_frame_latency", FW'(gotQ[1].cyc), FW'(fallK + RC + 3));
      end
      checkOutput("s1_frame", bus.frame, {24'hFF0000, 120'h0});
      checkEvents("s1");

      // Full frame of six pixels.
      for (int i = 0; i < 6; i++) sendPixel({8'(3*i+1), 8'(3*i+2), 8'(3*i+3)});
      sendGap();
      checkOutput("s2_frame", bus.frame, 144'h010203_040506_070809_0A0B0C_0D0E0F_101112);
      checkOutput("s2_led_count", FW'(bus.led_count), FW'(6));
      checkEvents("s2");

      // Eight pixels: only the first six are kept, but all are counted.
      for (int i = 0; i < 8; i++) sendPixel(24'($urandom));
      sendGap();
      checkOutput("s3_led_count", FW'(bus.led_count), FW'(8));
      checkEvents("s3");

      // Threshold edges, then a runt pulse that forces resynchronisation.
      sendPulse(28, 34);
      sendPulse(29, 33);
      for (int i = 21; i >= 0; i--) sendBit(1'((22'h2A5A5A >> i) & 1));
      if (gotQ.size() > 0) checkOutput("s4_threshold_pixel", gotQ[0].data, FW'(24'h6A5A5A));
      sendPulse(4, 60);
      sendPixel(24'h123456);
      sendGap();
      sendPixel(24'h00FF00);
      sendGap();
      checkOutput("s4_last_pixel", FW'(bus.pixel), FW'(24'h00FF00));
      checkEvents("s4");

      // Pixel plus six stray bits: err and frame_valid land together.
      sendPixel(24'hA5C3E1);
      for (int i = 0; i < 6; i++) sendBit(1'(i & 1));
      sendGap();
      if (gotQ.size() == 3)
         checkOutput("s5_err_with_frame", FW'(gotQ[2].cyc), FW'(gotQ[1].cyc));
      checkOutput("s5_led_count", FW'(bus.led_count), FW'(1));
      checkEvents("s5");

      // Reset mid-pixel, then an unsynchronised pixel that must be ignored.
      for (int i = 0; i < 12; i++) sendBit(1'(i % 3 == 0));
      checkEvents("s6_pre");
      doReset("midreset");
      sendPixel(24'h0F0F0F);
      sendGap();
      sendPixel(24'h5AA5C3);
      sendGap();
      checkEvents("s6");

      // Randomised frames with occasional bad pulses and stray bits.
      for (int f = 0; f < 3; f++) begin
         npix = int'($urandom_range(2, 1));
         for (int p = 0; p < npix; p++) begin
            logic [23:0] v;
            v = 24'($urandom);
            for (int i = 23; i >= 0; i--) sendRandBit(v[i]);
            if ($urandom_range(3, 0) == 0) begin
               if ($urandom_range(1, 0) == 0) sendPulse(int'($urandom_range(7, 1)), 40);
               else                           sendPulse(int'($urandom_range(66, 61)), 40);
               for (int i = 0; i < 3; i++) sendRandBit(1'($urandom));
            end
         end
         if ($urandom_range(3, 0) == 0) begin
            int nb;
            nb = int'($urandom_range(5, 1));
            for (int i = 0; i < nb; i++) sendRandBit(1'($urandom));
         end
         sendGap();
         checkEvents("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Single-wire WS2812-style NRZ decoder: the receive end of the LED strip protocol our strip driver transmits. It recovers 24-bit pixel words from `din` by measuring high-pulse width, detects the latch (reset) gap, and publishes a completed frame of up to `N_LEDS` pixels. It is used for loopback self-test of the strip driver on the FPGA and as a bench monitor.

## Interface
- `THRESH_CYCLES`, default 29: high time ≥ this decodes as 1, below decodes as 0 (0.6 µs at 48 MHz).
- `MIN_HIGH`, default 8: high pulses shorter than this are errors.
- `MAX_HIGH`, default 60: high pulses longer than this are errors.
- `RESET_CYCLES`, default 2400: consecutive low cycles that constitute a latch gap (50 µs).
- `N_LEDS`, default 6: pixels held in `frame`.
- `clk` in 1: system clock, 48 MHz.
- `rst` in 1: reset, synchronous, active-high.
- `din` in 1: asynchronous serial strip data.
- `pixel` out 24: last decoded pixel, MSB first on wire.
- `pixel_valid` out 1: one-cycle pulse per decoded pixel.
- `frame` out 24*N_LEDS: last completed frame. First received pixel is in `frame[24*N_LEDS-1 -: 24]`.
- `frame_valid` out 1: one-cycle pulse when `frame` updates.
- `led_count` out 10: pixels in the last completed frame. Saturates at 1023.
- `err` out 1: one-cycle pulse on a protocol error.

## Operation
- `din` passes through a 2-flop synchronizer, giving `din_s`. A third flop provides edge detection.
- Reset values: all outputs 0; state `SYNC`; shadow frame, bit and pixel counters cleared.
- States:
  - `SYNC`: count consecutive `din_s` low cycles; any high clears the count. When the count reaches `RESET_CYCLES`, go to `LOW`. No decoding occurs here, so a frame started without a preceding gap is ignored.
  - `LOW`: a rising edge goes to `HIGH` with `high_cnt`=1. `low_cnt` increments and saturates. When `low_cnt` reaches `RESET_CYCLES`, latch-gap handling runs once and the machine stays in `LOW`.
  - `HIGH`: `high_cnt` increments and saturates at `MAX_HIGH`+1. On a falling edge, `low_cnt` is set to 1, then:
    - If `MIN_HIGH` ≤ `high_cnt` ≤ `MAX_HIGH`: shift bit (`high_cnt` ≥ `THRESH_CYCLES`) into `shreg` LSB, then go to `LOW`.
    - Otherwise: pulse `err`, clear `shreg`, bit count, shadow frame and pixel count, then go to `SYNC`.
  - When `high_cnt` exceeds `MAX_HIGH` while still high: same error action, applied immediately.
- Pixel completion (24th bit):
  - Load `pixel`, pulse `pixel_valid`, reset bit count.
  - If pixel count < `N_LEDS`, write into the shadow frame slot (index = count, slot 0 = MSB end).
  - Increment pixel count. Pixels beyond `N_LEDS` still pulse `pixel_valid` and count, but are not stored.
- Latch gap with pixel count > 0:
  - Copy shadow frame to `frame`; unfilled slots are 0.
  - `led_count` = pixel count; pulse `frame_valid`.
  - Clear shadow frame and pixel count.
- Latch gap with a nonzero partial bit count: pulse `err` in the same cycle and discard the partial bits. `frame_valid` still fires if pixel count > 0.
- Latch gap with no pixels and no bits: no output.
- `pixel`, `frame` and `led_count` hold until overwritten.
- `rst` mid-frame restores the reset values next cycle and returns to `SYNC`.

## Timing
- Raw `din` edge to state machine action: 3 cycles (2 sync + edge flop).
- `pixel_valid` is high the cycle after the 24th falling edge is seen on `din_s`. `pixel` is valid in that same cycle.
- `frame_valid` is high the cycle after `low_cnt` reaches `RESET_CYCLES`, i.e. `RESET_CYCLES`+1 cycles after the last falling edge on `din_s`. `frame` and `led_count` are valid in that same cycle.
- All pulses are exactly 1 cycle. `err` and `frame_valid` may coincide.
- Minimum sustained bit period is `MAX_HIGH`+2 cycles of low-to-low. No back-pressure: the consumer must sample on pulses.

## Structure
- Package `ws_pkg`:
  - State enum `rx_state_t` (`SYNC`, `LOW`, `HIGH`).
  - `BITS_PER_LED`=24.
  - Default timing constants, shared with the strip driver.
- Sub-module `din_sync`: 2-flop synchronizer plus edge flop, outputting `din_s`, `rise` and `fall`.
- Counters are inline with explicit saturation widths: `low_cnt` of `$clog2(RESET_CYCLES+1)` bits; `high_cnt` of 7 bits.

## Test plan
Bit 0 = 19 high / 41 low cycles; bit 1 = 38 high / 22 low cycles; gap = 2500 low cycles.
- Gap, pixel 0xFF0000, gap → one `pixel_valid` with `pixel`=0xFF0000; `frame_valid` with `led_count`=1; `frame`={0xFF0000, 120'h0}.
- Gap, pixels 0x010203, 0x040506 … 0x10_11_12 (6), gap → six `pixel_valid`; `frame`=0x010203_040506_070809_0A0B0C_0D0E0F_101112; `led_count`=6.
- Gap, 8 pixels, gap → eight `pixel_valid`; `frame` holds the first 6; `led_count`=8.
- Threshold: a pixel using high widths 28 and 29 for bits 23 and 22 → bit 23=0, bit 22=1. A 4-cycle high pulse → `err` pulse, state `SYNC`, no `pixel_valid` until gap, then the next pixel 0x00FF00 decodes correctly.
- 30 bits then gap → one `pixel_valid`, `err` and `frame_valid` in the same cycle, `led_count`=1.
- `rst` after 12 bits → all outputs 0. A pixel sent without a preceding gap is ignored; after a gap the next pixel decodes.
